// File: rtl/clock_set_ctrl_if.sv
// Button / enable / pulse bundle between the clock front panel and clock_set_ctrl.
// master drives the enable and the debounced button levels; slave is the sequencer.
interface clock_set_ctrl_if;
    logic       en1hz;
    logic       btn_mode;
    logic       btn_up;
    logic       btn_clr;
    logic       run_en;
    logic       secup;
    logic       minup;
    logic       clr;
    logic [3:0] blank;
    logic [1:0] mode;

    modport master (
        output en1hz, btn_mode, btn_up, btn_clr,
        input  run_en, secup, minup, clr, blank, mode
    );

    modport slave (
        input  en1hz, btn_mode, btn_up, btn_clr,
        output run_en, secup, minup, clr, blank, mode
    );
endinterface

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: mode/set sequencer for the MM:SS clock.
// Gates the 1 Hz enable, turns button presses into one-cycle secup/minup/clr
// pulses, blinks the digit pair being set and drops back to RUN after an idle
// timeout. Optional auto-repeat on a held UP button is enabled by defining
// the macro CLOCK_SET_AUTOREPEAT_EN.
module clock_set_ctrl #(
    parameter int BLINK_HALF = 25_000_000,
    parameter int TIMEOUT_S  = 10,
    parameter int RPT_DLY    = 25_000_000,
    parameter int RPT_PER    = 5_000_000
) (
    input  logic             clk,
    input  logic             rst,
    clock_set_ctrl_if.slave  bus
);
    localparam int BW = $clog2(BLINK_HALF) + 1;
    localparam int TW = $clog2(TIMEOUT_S + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_S - 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_MIN = 2'd1,
        SET_SEC = 2'd2
    } state_t;

    state_t        state;
    state_t        state_n;
    logic          prev_mode;
    logic          prev_up;
    logic          prev_clr;
    logic [BW-1:0] blink_cnt;
    logic [BW-1:0] blink_cnt_n;
    logic          phase;
    logic          phase_n;
    logic [TW-1:0] to_cnt;
    logic [TW-1:0] to_cnt_n;
    logic          press_mode;
    logic          press_up;
    logic          press_clr;
    logic          in_set;
    logic          rpt_fire;
    logic          activity;
    logic          timeout_hit;
    logic          up_fire;
    logic          blink_restart;
    logic [3:0]    blank_n;

    assign press_mode  = bus.btn_mode & ~prev_mode;
    assign press_up    = bus.btn_up   & ~prev_up;
    assign press_clr   = bus.btn_clr  & ~prev_clr;
    assign in_set      = (state != RUN);
    assign activity    = press_mode | press_up | press_clr | rpt_fire;
    assign timeout_hit = in_set & ~activity & bus.en1hz & (to_cnt == TO_LAST);
    assign up_fire     = in_set & ~press_mode & ~press_clr & (press_up | rpt_fire);
    assign blink_restart = up_fire | press_mode;

    assign bus.run_en = bus.en1hz & (state == RUN);

`ifdef CLOCK_SET_AUTOREPEAT_EN
    localparam int RW = $clog2((RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER) + 1;
    localparam logic [RW-1:0] DLY_LAST = RW'(RPT_DLY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(RPT_PER - 1);

    logic          rpt_armed;
    logic          rpt_started;
    logic [RW-1:0] rpt_cnt;

    assign rpt_fire = rpt_armed & bus.btn_up &
                      (rpt_cnt == (rpt_started ? PER_LAST : DLY_LAST));

    // Hold timer for UP: arms on an accepted press, first repeat after the long delay, then periodic
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_armed   <= 1'b0;
            rpt_started <= 1'b0;
            rpt_cnt     <= '0;
        end else if (up_fire & press_up) begin
            rpt_armed   <= 1'b1;
            rpt_started <= 1'b0;
            rpt_cnt     <= '0;
        end else if (press_mode | timeout_hit | ~bus.btn_up | ~in_set) begin
            rpt_armed   <= 1'b0;
            rpt_started <= 1'b0;
            rpt_cnt     <= '0;
        end else if (rpt_armed) begin
            if (rpt_fire) begin
                rpt_cnt     <= '0;
                rpt_started <= 1'b1;
            end else begin
                rpt_cnt <= rpt_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_rpt;
    assign rpt_fire   = 1'b0;
    assign unused_rpt = (RPT_DLY > 0) ^ (RPT_PER > 0);
`endif

    // Next state, blink phase, idle count and blank mask derived from this cycle's events
    always_comb begin
        state_n = state;
        if (timeout_hit) begin
            state_n = RUN;
        end else if (press_mode) begin
            case (state)
                RUN:     state_n = SET_MIN;
                SET_MIN: state_n = SET_SEC;
                default: state_n = RUN;
            endcase
        end

        blink_cnt_n = blink_cnt + 1'b1;
        phase_n     = phase;
        if (state_n == RUN || blink_restart) begin
            blink_cnt_n = '0;
            phase_n     = 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt_n = '0;
            phase_n     = ~phase;
        end

        to_cnt_n = to_cnt;
        if (!in_set || activity || timeout_hit) begin
            to_cnt_n = '0;
        end else if (bus.en1hz) begin
            to_cnt_n = to_cnt + 1'b1;
        end

        case (state_n)
            SET_MIN: blank_n = {phase_n, phase_n, 2'b00};
            SET_SEC: blank_n = {2'b00, phase_n, phase_n};
            default: blank_n = 4'b0000;
        endcase
    end

    // Sequencer FSM with registered pulse, blank and mode outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            prev_mode <= 1'b0;
            prev_up   <= 1'b0;
            prev_clr  <= 1'b0;
            blink_cnt <= '0;
            phase     <= 1'b0;
            to_cnt    <= '0;
            bus.secup <= 1'b0;
            bus.minup <= 1'b0;
            bus.clr   <= 1'b0;
            bus.blank <= 4'b0000;
            bus.mode  <= 2'd0;
        end else begin
            state     <= state_n;
            prev_mode <= bus.btn_mode;
            prev_up   <= bus.btn_up;
            prev_clr  <= bus.btn_clr;
            blink_cnt <= blink_cnt_n;
            phase     <= phase_n;
            to_cnt    <= to_cnt_n;
            bus.clr   <= ~press_mode & press_clr;
            bus.minup <= up_fire & (state == SET_MIN);
            bus.secup <= up_fire & (state == SET_SEC);
            bus.blank <= blank_n;
            bus.mode  <= state_n;
        end
    end
endmodule
